axi_lite_bridge_p: RTL and testbench

AXI_LITE_BRIDGE_P -- requirements
Module: axi_lite_bridge_p

---
 rtl/axi_lite_bridge_p_if.sv | 59 +++++
 rtl/axi_lite_bridge_p.sv | 171 +++++++++++++++++
 tb/tb_axi_lite_bridge_p.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_bridge_p_if.sv
// Bundle of client-side and AXI4-Lite signals for axi_lite_bridge_p.
// The "master" modport is the bridge's view: it masters the AXI bus and
// serves the client. The "slave" modport is the environment's view: the
// client plus the AXI slave.
interface axi_lite_bridge_p_if #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 17,
    parameter int C_ADDR_W = 8
);
    // client side
    logic                C_in_valid;
    logic                C_in_ready;
    logic                C_r_wb;
    logic [C_ADDR_W-1:0] C_addr;
    logic [DATA_W-1:0]   C_data_w;
    logic                C_out_valid;
    logic [DATA_W-1:0]   C_data_r;
    logic                C_err;

    // AXI read channels
    logic                AR_VALID;
    logic                AR_READY;
    logic [ADDR_W-1:0]   AR_ADDR;
    logic                R_VALID;
    logic                R_READY;
    logic [DATA_W-1:0]   R_DATA;
    logic [1:0]          R_RESP;

    // AXI write channels
    logic                AW_VALID;
    logic                AW_READY;
    logic [ADDR_W-1:0]   AW_ADDR;
    logic                W_VALID;
    logic                W_READY;
    logic [DATA_W-1:0]   W_DATA;
    logic                B_VALID;
    logic                B_READY;
    logic [1:0]          B_RESP;

    modport master (
        input  C_in_valid, C_r_wb, C_addr, C_data_w,
        output C_in_ready, C_out_valid, C_data_r, C_err,
        output AR_VALID, AR_ADDR, input AR_READY,
        input  R_VALID, R_DATA, R_RESP, output R_READY,
        output AW_VALID, AW_ADDR, input AW_READY,
        output W_VALID, W_DATA, input W_READY,
        input  B_VALID, B_RESP, output B_READY
    );

    modport slave (
        output C_in_valid, C_r_wb, C_addr, C_data_w,
        input  C_in_ready, C_out_valid, C_data_r, C_err,
        input  AR_VALID, AR_ADDR, output AR_READY,
        output R_VALID, R_DATA, R_RESP, input R_READY,
        input  AW_VALID, AW_ADDR, output AW_READY,
        input  W_VALID, W_DATA, output W_READY,
        output B_VALID, B_RESP, input B_READY
    );
endinterface

// File: rtl/axi_lite_bridge_p.sv
// Single-outstanding client-to-AXI4-Lite bridge.
// A client request (read or write) is translated into one AXI-Lite
// transaction; completion is reported with a one-cycle C_out_valid pulse.
// All outputs are registered and driven from one state machine.
// Optional feature: define BRIDGE_TIMEOUT_EN to add a watchdog that aborts
// a transaction with C_err=1 after TIMEOUT_CYC waiting cycles.
module axi_lite_bridge_p #(
    parameter int              DATA_W      = 64,
    parameter int              ADDR_W      = 17,
    parameter int              C_ADDR_W    = 8,
    parameter int              ADDR_SHIFT  = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 17'h10000,
    parameter int              TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_lite_bridge_p_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t state_r;

    // Word address to AXI byte address; the sum wraps at ADDR_W bits.
    function automatic logic [ADDR_W-1:0] byte_addr(input logic [C_ADDR_W-1:0] word_addr);
        logic [ADDR_W-1:0] ext;
        ext = ADDR_W'(word_addr);
        return BASE_ADDR + (ext << ADDR_SHIFT);
    endfunction

`ifdef BRIDGE_TIMEOUT_EN
    logic [31:0] wait_cnt_r;
    logic        in_wait_s;
    logic        timeout_hit_s;

    // Waiting states are every state with an AXI handshake still pending.
    assign in_wait_s     = (state_r == RD_ADDR) || (state_r == RD_DATA) ||
                           (state_r == WR_REQ)  || (state_r == WR_RESP);
    // The current waiting cycle is the TIMEOUT_CYC-th one since accept.
    assign timeout_hit_s = ((wait_cnt_r + 32'd1) >= 32'(TIMEOUT_CYC));
`endif

    // Transaction state machine; every output is a register written here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            bus.C_in_ready  <= 1'b1;
            bus.C_out_valid <= 1'b0;
            bus.C_data_r    <= {DATA_W{1'b0}};
            bus.C_err       <= 1'b0;
            bus.AR_VALID    <= 1'b0;
            bus.AR_ADDR     <= {ADDR_W{1'b0}};
            bus.R_READY     <= 1'b0;
            bus.AW_VALID    <= 1'b0;
            bus.AW_ADDR     <= {ADDR_W{1'b0}};
            bus.W_VALID     <= 1'b0;
            bus.W_DATA      <= {DATA_W{1'b0}};
            bus.B_READY     <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
            wait_cnt_r      <= 32'd0;
`endif
        end else begin
`ifdef BRIDGE_TIMEOUT_EN
            if (in_wait_s) begin
                wait_cnt_r <= wait_cnt_r + 32'd1;
            end
            // Watchdog wins over any handshake completing on the same edge.
            if (in_wait_s && timeout_hit_s) begin
                bus.AR_VALID    <= 1'b0;
                bus.R_READY     <= 1'b0;
                bus.AW_VALID    <= 1'b0;
                bus.W_VALID     <= 1'b0;
                bus.B_READY     <= 1'b0;
                bus.C_out_valid <= 1'b1;
                bus.C_data_r    <= {DATA_W{1'b0}};
                bus.C_err       <= 1'b1;
                state_r         <= DONE;
            end else
`endif
            begin
                case (state_r)
                    IDLE: begin
                        if (bus.C_in_valid && bus.C_in_ready) begin
                            bus.C_in_ready <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
                            wait_cnt_r     <= 32'd0;
`endif
                            if (bus.C_r_wb) begin
                                bus.AR_ADDR  <= byte_addr(bus.C_addr);
                                bus.AR_VALID <= 1'b1;
                                state_r      <= RD_ADDR;
                            end else begin
                                bus.AW_ADDR  <= byte_addr(bus.C_addr);
                                bus.W_DATA   <= bus.C_data_w;
                                bus.AW_VALID <= 1'b1;
                                bus.W_VALID  <= 1'b1;
                                state_r      <= WR_REQ;
                            end
                        end
                    end
                    RD_ADDR: begin
                        if (bus.AR_READY) begin
                            bus.AR_VALID <= 1'b0;
                            bus.R_READY  <= 1'b1;
                            state_r      <= RD_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (bus.R_VALID) begin
                            bus.R_READY     <= 1'b0;
                            bus.C_out_valid <= 1'b1;
                            bus.C_data_r    <= bus.R_DATA;
                            bus.C_err       <= (bus.R_RESP != 2'b00);
                            state_r         <= DONE;
                        end
                    end
                    WR_REQ: begin
                        // AW and W retire independently, in any order.
                        if (bus.AW_VALID && bus.AW_READY) begin
                            bus.AW_VALID <= 1'b0;
                        end
                        if (bus.W_VALID && bus.W_READY) begin
                            bus.W_VALID <= 1'b0;
                        end
                        if ((!bus.AW_VALID || bus.AW_READY) &&
                            (!bus.W_VALID  || bus.W_READY)) begin
                            bus.B_READY <= 1'b1;
                            state_r     <= WR_RESP;
                        end
                    end
                    WR_RESP: begin
                        if (bus.B_VALID) begin
                            bus.B_READY     <= 1'b0;
                            bus.C_out_valid <= 1'b1;
                            bus.C_data_r    <= {DATA_W{1'b0}};
                            bus.C_err       <= (bus.B_RESP != 2'b00);
                            state_r         <= DONE;
                        end
                    end
                    DONE: begin
                        bus.C_out_valid <= 1'b0;
                        bus.C_data_r    <= {DATA_W{1'b0}};
                        bus.C_err       <= 1'b0;
                        bus.C_in_ready  <= 1'b1;
                        state_r         <= IDLE;
                    end
                    default: begin
                        bus.AR_VALID    <= 1'b0;
                        bus.R_READY     <= 1'b0;
                        bus.AW_VALID    <= 1'b0;
                        bus.W_VALID     <= 1'b0;
                        bus.B_READY     <= 1'b0;
                        bus.C_out_valid <= 1'b0;
                        bus.C_data_r    <= {DATA_W{1'b0}};
                        bus.C_err       <= 1'b0;
                        bus.C_in_ready  <= 1'b1;
                        state_r         <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_bridge_p.sv
// Self-checking bench for axi_lite_bridge_p: a table of transactions
// (directed plus random) is played through a cycle-level AXI slave model,
// with expectations computed from the bridge's documented behaviour.
module tb_axi_lite_bridge_p;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 17;
    localparam int C_ADDR_W = 8;
`ifdef BRIDGE_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 255;
    localparam bit TO_EN = 1'b0;
`endif
    localparam int NVEC = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_lite_bridge_p_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .C_ADDR_W(C_ADDR_W)) bus ();

    axi_lite_bridge_p #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .C_ADDR_W(C_ADDR_W),
        .ADDR_SHIFT(3), .BASE_ADDR(17'h10000), .TIMEOUT_CYC(TO)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          r_wb;
        logic [7:0]  addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [1:0]  resp;
        int          d_a;      // AR (read) or AW (write) ready delay
        int          d_w;      // W ready delay
        int          d_x;      // R / B valid delay
        bit          noise;    // drive the unrelated response channel
        bit          hold;     // keep C_in_valid high while busy
        logic [16:0] exp_addr;
        logic [63:0] exp_data;
        bit          exp_err;
        int          exp_lat;  // edges from accept to C_out_valid sample
    } vec_t;

    vec_t tbl [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Behavioural expectation: address arithmetic, latency from wait counts.
    function automatic vec_t model(input vec_t v);
        int baddr;
        int wait_a;
        int lat;
        baddr      = (32'h10000 + int'(v.addr) * 8) % 32'h20000;
        v.exp_addr = 17'(baddr);
        wait_a     = v.r_wb ? v.d_a : ((v.d_a > v.d_w) ? v.d_a : v.d_w);
        lat        = 3 + wait_a + v.d_x;
        v.exp_data = v.r_wb ? v.rdata : 64'd0;
        v.exp_err  = (v.resp != 2'b00);
        if (TO_EN && (lat - 1 >= TO)) begin
            lat        = TO;
            v.exp_data = 64'd0;
            v.exp_err  = 1'b1;
        end
        v.exp_lat = lat;
        return v;
    endfunction

    function automatic vec_t mk(input bit r_wb, input logic [7:0] addr,
                                input logic [63:0] wdata, input logic [63:0] rdata,
                                input logic [1:0] resp, input int d_a, input int d_w,
                                input int d_x, input bit noise, input bit hold);
        vec_t v;
        v.r_wb = r_wb; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.resp = resp; v.d_a = d_a; v.d_w = d_w; v.d_x = d_x;
        v.noise = noise; v.hold = hold;
        return model(v);
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, 64'({bus.AR_VALID, bus.R_READY, bus.AW_VALID, bus.W_VALID,
                                bus.B_READY, bus.C_out_valid, bus.C_err, bus.C_in_ready}), 64'h01);
        chk({tag, "_addrs"}, 64'({bus.AR_ADDR, bus.AW_ADDR}), 64'd0);
        chk({tag, "_wdata"}, bus.W_DATA, 64'd0);
        chk({tag, "_rdata"}, bus.C_data_r, 64'd0);
    endtask

    task automatic clear_slave();
        bus.AR_READY = 1'b0; bus.AW_READY = 1'b0; bus.W_READY = 1'b0;
        bus.R_VALID  = 1'b0; bus.R_DATA   = 64'd0; bus.R_RESP  = 2'b00;
        bus.B_VALID  = 1'b0; bus.B_RESP   = 2'b00;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    n, ar_seen, aw_seen, w_seen, x_seen;
        bit    got, ar_hs, aw_hs, w_hs, x_done;
        bit    addr_bad, wdata_bad, inv_bad, hs_bad;
        string tag;
        n = 0; ar_seen = 0; aw_seen = 0; w_seen = 0; x_seen = 0;
        got = 0; ar_hs = 0; aw_hs = 0; w_hs = 0; x_done = 0;
        addr_bad = 0; wdata_bad = 0; inv_bad = 0; hs_bad = 0;
        tag = $sformatf("v%0d", idx);

        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(bus.C_in_ready), 64'd1);
        bus.C_in_valid = 1'b1; bus.C_r_wb = v.r_wb;
        bus.C_addr = v.addr;   bus.C_data_w = v.wdata;

        while (!got && n < 80) begin
            @(negedge clk);
            n++;
            // handshakes offered last cycle completed on the edge just passed
            if (bus.AR_READY) ar_hs = 1;
            if (bus.AW_READY) aw_hs = 1;
            if (bus.W_READY)  w_hs  = 1;
            if (v.r_wb ? bus.R_VALID : bus.B_VALID) x_done = 1;
            if (!v.hold) bus.C_in_valid = 1'b0;
            clear_slave();
            if (bus.C_out_valid) begin
                got = 1;
                bus.C_in_valid = 1'b0;
                chk({tag, "_latency"}, 64'(n), 64'(v.exp_lat));
                chk({tag, "_data_r"}, bus.C_data_r, v.exp_data);
                chk({tag, "_err"}, 64'(bus.C_err), 64'(v.exp_err));
                chk({tag, "_bus_idle_done"}, 64'({bus.AR_VALID, bus.R_READY, bus.AW_VALID,
                                                   bus.W_VALID, bus.B_READY}), 64'd0);
            end else begin
                if (bus.C_data_r != 64'd0 || bus.C_err || bus.C_in_ready) inv_bad = 1;
                if (v.noise) begin
                    if (v.r_wb) begin
                        bus.B_VALID = 1'b1; bus.B_RESP = 2'b11;
                    end else begin
                        bus.R_VALID = 1'b1; bus.R_RESP = 2'b11;
                        bus.R_DATA  = {$urandom(), $urandom()};
                    end
                end
                if (v.r_wb) begin
                    if (bus.AW_VALID || bus.W_VALID || bus.B_READY) hs_bad = 1;
                    if (bus.R_READY && !ar_hs) hs_bad = 1;
                    if (ar_hs && bus.AR_VALID) hs_bad = 1;
                    if (!ar_hs && bus.AR_VALID) begin
                        if (bus.AR_ADDR !== v.exp_addr) addr_bad = 1;
                        if (ar_seen >= v.d_a) bus.AR_READY = 1'b1;
                        ar_seen++;
                    end
                    if (ar_hs && !x_done && bus.R_READY) begin
                        if (x_seen >= v.d_x) begin
                            bus.R_VALID = 1'b1; bus.R_DATA = v.rdata; bus.R_RESP = v.resp;
                        end
                        x_seen++;
                    end
                end else begin
                    if (bus.AR_VALID || bus.R_READY) hs_bad = 1;
                    if (bus.B_READY && !(aw_hs && w_hs)) hs_bad = 1;
                    if ((aw_hs && bus.AW_VALID) || (w_hs && bus.W_VALID)) hs_bad = 1;
                    if (!aw_hs && bus.AW_VALID) begin
                        if (bus.AW_ADDR !== v.exp_addr) addr_bad = 1;
                        if (aw_seen >= v.d_a) bus.AW_READY = 1'b1;
                        aw_seen++;
                    end
                    if (!w_hs && bus.W_VALID) begin
                        if (bus.W_DATA !== v.wdata) wdata_bad = 1;
                        if (w_seen >= v.d_w) bus.W_READY = 1'b1;
                        w_seen++;
                    end
                    if (bus.B_READY && aw_hs && w_hs && !x_done) begin
                        if (x_seen >= v.d_x) begin
                            bus.B_VALID = 1'b1; bus.B_RESP = v.resp;
                        end
                        x_seen++;
                    end
                end
            end
        end
        clear_slave();
        bus.C_in_valid = 1'b0;
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        chk({tag, "_addr"}, 64'(addr_bad), 64'd0);
        chk({tag, "_wdata"}, 64'(wdata_bad), 64'd0);
        chk({tag, "_busy_outputs"}, 64'(inv_bad), 64'd0);
        chk({tag, "_handshake_order"}, 64'(hs_bad), 64'd0);
        @(negedge clk);
        chk({tag, "_pulse_end"}, 64'({bus.C_out_valid, bus.C_err, bus.C_in_ready}), 64'h1);
        chk({tag, "_pulse_end_data"}, bus.C_data_r, 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit late_bad;
        rst = 1'b1;
        bus.C_in_valid = 1'b0; bus.C_r_wb = 1'b0; bus.C_addr = 8'd0; bus.C_data_w = 64'd0;
        clear_slave();

        tbl[0] = mk(1'b1, 8'h05, 64'd0, 64'hDEAD_BEEF_0123_4567, 2'b00, 0, 0, 0, 1'b0, 1'b0);
        tbl[1] = mk(1'b0, 8'hFF, 64'h1, 64'd0, 2'b00, 2, 0, 0, 1'b0, 1'b0);
        tbl[2] = mk(1'b0, 8'h3C, 64'hCAFE_F00D, 64'd0, 2'b10, 1, 1, 1, 1'b0, 1'b1);
        tbl[3] = mk(1'b1, 8'h00, 64'd0, 64'h0000_0000_0000_0055, 2'b11, 1, 0, 2, 1'b1, 1'b0);
        tbl[4] = mk(1'b0, 8'h10, 64'hA5A5_5A5A_A5A5_5A5A, 64'd0, 2'b00, 0, 3, 0, 1'b1, 1'b1);
        tbl[5] = mk(1'b1, 8'h80, 64'd0, 64'h1234, 2'b00, 40, 0, 0, 1'b0, 1'b0);
        for (int i = 6; i < NVEC; i++) begin
            tbl[i] = mk(1'($urandom_range(0, 1)), 8'($urandom()),
                        {$urandom(), $urandom()}, {$urandom(), $urandom()},
                        ($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'b00,
                        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_idle("reset");

        for (int i = 0; i < NVEC; i++) begin
            run_vec(tbl[i], i);
        end

        // Reset while waiting for read data aborts silently.
        @(negedge clk);
        bus.C_in_valid = 1'b1; bus.C_r_wb = 1'b1; bus.C_addr = 8'h21;
        @(negedge clk);
        bus.C_in_valid = 1'b0;
        bus.AR_READY = bus.AR_VALID;
        @(negedge clk);
        bus.AR_READY = 1'b0;
        chk("abort_in_rd_data", 64'(bus.R_READY), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("abort");
        bus.R_VALID = 1'b1; bus.R_DATA = 64'hFFFF_0000_FFFF_0000; bus.R_RESP = 2'b10;
        late_bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.C_out_valid || bus.R_READY || !bus.C_in_ready || bus.C_data_r != 64'd0)
                late_bad = 1'b1;
        end
        clear_slave();
        chk("abort_late_r_valid", 64'(late_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
